pc_gen_unit: RTL and testbench

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

---
 rtl/pc_gen_unit_pkg.sv | 10 +
 rtl/pc_gen_unit_if.sv | 44 ++++
 rtl/pc_gen_unit_pc_target_calc.sv | 20 ++
 rtl/pc_gen_unit.sv | 62 ++++++
 tb/tb_pc_gen_unit.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_unit_pkg.sv
// pc_gen_unit_pkg: shared FSM state, instruction length constants and the
// link-length decode used by the PC generator.
package pc_gen_unit_pkg;
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  localparam int ILEN32 = 4;
  localparam int ILEN16 = 2;
  function automatic logic [2:0] link_len(input logic [1:0] lo, input logic c_ext);
    return (lo == 2'b11 || !c_ext) ? 3'(ILEN32) : 3'(ILEN16);
  endfunction
endpackage

// File: rtl/pc_gen_unit_if.sv
// pc_gen_unit_if: fetch, EX-redirect and trap signals of the PC generator.
// redirect_cnt_o exists only when PC_REDIRECT_CNT_EN is defined.
interface pc_gen_unit_if #(parameter int XLEN = 32);
  logic fetch_ready_i;
  logic instr_valid_i;
  logic [1:0] instr_lo_i;
  logic stall_i;
  logic ex_branch_i;
  logic ex_jal_i;
  logic ex_jalr_i;
  logic [XLEN-1:0] ex_pc_i;
  logic [XLEN-1:0] ex_imm_i;
  logic [XLEN-1:0] ex_rs1_i;
  logic trap_clear_i;
  logic [XLEN-1:0] trap_vec_i;
  logic [XLEN-1:0] pc_o;
  logic pc_valid_o;
  logic redirect_o;
  logic misalign_o;
`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt_o;
  modport master(
    input fetch_ready_i, instr_valid_i, instr_lo_i, stall_i, ex_branch_i, ex_jal_i, ex_jalr_i,
    input ex_pc_i, ex_imm_i, ex_rs1_i, trap_clear_i, trap_vec_i,
    output pc_o, pc_valid_o, redirect_o, misalign_o, redirect_cnt_o
  );
  modport slave(
    output fetch_ready_i, instr_valid_i, instr_lo_i, stall_i, ex_branch_i, ex_jal_i, ex_jalr_i,
    output ex_pc_i, ex_imm_i, ex_rs1_i, trap_clear_i, trap_vec_i,
    input pc_o, pc_valid_o, redirect_o, misalign_o, redirect_cnt_o
  );
`else
  modport master(
    input fetch_ready_i, instr_valid_i, instr_lo_i, stall_i, ex_branch_i, ex_jal_i, ex_jalr_i,
    input ex_pc_i, ex_imm_i, ex_rs1_i, trap_clear_i, trap_vec_i,
    output pc_o, pc_valid_o, redirect_o, misalign_o
  );
  modport slave(
    output fetch_ready_i, instr_valid_i, instr_lo_i, stall_i, ex_branch_i, ex_jal_i, ex_jalr_i,
    output ex_pc_i, ex_imm_i, ex_rs1_i, trap_clear_i, trap_vec_i,
    input pc_o, pc_valid_o, redirect_o, misalign_o
  );
`endif
endinterface

// File: rtl/pc_gen_unit_pc_target_calc.sv
// pc_target_calc: redirect target and misalignment flag for the EX instruction.
module pc_target_calc #(
  parameter int XLEN = 32,
  parameter int C_EXT = 1
) (
  input  logic            jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);
  logic [XLEN-1:0] jalr_sum;
  // branch and jal share pc+imm, so only jalr needs to win the select
  always_comb begin
    jalr_sum = rs1 + imm;
    target = jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc + imm;
    misaligned = target[0] | ((C_EXT == 0) && target[1]);
  end
endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC generator with BOOT/RUN/TRAP FSM and EX redirects.
// Optional PC_REDIRECT_CNT_EN adds a saturating accepted-redirect counter.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int C_EXT = 1
) (
  input logic clk,
  input logic rst_n,
  pc_gen_unit_if.master bus
);
  state_t state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, target;
  logic misaligned, redirect, advance;
  pc_target_calc #(.XLEN(XLEN), .C_EXT(C_EXT)) u_calc (
    .jalr(bus.ex_jalr_i),
    .pc(bus.ex_pc_i),
    .imm(bus.ex_imm_i),
    .rs1(bus.ex_rs1_i),
    .target(target),
    .misaligned(misaligned)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
    end
  end
  // unreachable encodings behave like BOOT and recover into RUN
  always_comb begin
    redirect = bus.ex_branch_i | bus.ex_jal_i | bus.ex_jalr_i;
    advance = bus.fetch_ready_i & bus.instr_valid_i & !bus.stall_i & !redirect;
    state_nxt = (state == TRAP) ? (bus.trap_clear_i ? RUN : TRAP) :
                (state == RUN) ? ((redirect && misaligned) ? TRAP : RUN) : RUN;
    pc_nxt = (state == TRAP) ? (bus.trap_clear_i ? bus.trap_vec_i : pc) :
             (state == RUN) ? (redirect ? target :
                               advance ? pc + XLEN'(link_len(bus.instr_lo_i, C_EXT != 0)) : pc) :
             RESET_VECTOR;
  end
  always_comb begin
    bus.pc_o = pc;
    bus.pc_valid_o = state == RUN;
    bus.misalign_o = state == TRAP;
    bus.redirect_o = redirect;
  end
`ifdef PC_REDIRECT_CNT_EN
  logic [31:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (state == RUN && redirect && cnt != '1) cnt <= cnt + 32'd1;
  end
  assign bus.redirect_cnt_o = cnt;
`else
  logic unused_cnt;
  assign unused_cnt = 1'b0;
`endif
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed vector table on a C_EXT=1 instance plus hand
// sequences for boot, reset-in-trap and a C_EXT=0 instance.
module tb_pc_gen_unit;
  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  pc_gen_unit_if #(.XLEN(32)) ifa ();
  pc_gen_unit_if #(.XLEN(32)) ifb ();
  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa));
  pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h1000), .C_EXT(0)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb));

  typedef struct {
    logic fr, iv;
    logic [1:0] lo;
    logic st, br, jal, jalr;
    logic [31:0] epc, imm, rs1;
    logic tclr;
    logic [31:0] tvec;
    logic e_red;
    logic [31:0] e_pc;
    logic e_val, e_mis, e_inc;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    ifa.fetch_ready_i = v.fr;
    ifa.instr_valid_i = v.iv;
    ifa.instr_lo_i = v.lo;
    ifa.stall_i = v.st;
    ifa.ex_branch_i = v.br;
    ifa.ex_jal_i = v.jal;
    ifa.ex_jalr_i = v.jalr;
    ifa.ex_pc_i = v.epc;
    ifa.ex_imm_i = v.imm;
    ifa.ex_rs1_i = v.rs1;
    ifa.trap_clear_i = v.tclr;
    ifa.trap_vec_i = v.tvec;
  endtask

  task automatic drive_b(input logic br, input logic [31:0] epc, input logic [31:0] imm,
                         input logic tclr, input logic [31:0] tvec);
    ifb.fetch_ready_i = 1'b1;
    ifb.instr_valid_i = 1'b1;
    ifb.instr_lo_i = 2'b01;
    ifb.stall_i = 1'b0;
    ifb.ex_branch_i = br;
    ifb.ex_jal_i = 1'b0;
    ifb.ex_jalr_i = 1'b0;
    ifb.ex_pc_i = epc;
    ifb.ex_imm_i = imm;
    ifb.ex_rs1_i = 32'h0;
    ifb.trap_clear_i = tclr;
    ifb.trap_vec_i = tvec;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] pc, input logic val, input logic mis);
    chk({tag, ".pc"}, ifa.pc_o, pc);
    chk({tag, ".valid"}, 32'(ifa.pc_valid_o), 32'(val));
    chk({tag, ".misalign"}, 32'(ifa.misalign_o), 32'(mis));
  endtask

  task automatic chk_b(input string tag, input logic [31:0] pc, input logic val, input logic mis);
    chk({tag, ".pc"}, ifb.pc_o, pc);
    chk({tag, ".valid"}, 32'(ifb.pc_valid_o), 32'(val));
    chk({tag, ".misalign"}, 32'(ifb.misalign_o), 32'(mis));
  endtask

  initial begin
`ifdef PC_REDIRECT_CNT_EN
    logic [31:0] cnt_before;
`endif
    //        fr    iv    lo     st    br    jal   jalr  epc           imm          rs1          tclr  tvec          red   pc            val   mis   inc
    tbl[0]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h4,        1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h8,        1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF8,       32'h8,       32'h0,       1'b0, 32'h0,        1'b1, 32'h100,      1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h102,      1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h102,      1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h102,      1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h102,      1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        32'h10,      32'h2001,    1'b0, 32'h0,        1'b1, 32'h2010,     1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h2014,     1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h8,       32'h0,       1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300,      32'h20,      32'h1000,    1'b0, 32'h0,        1'b1, 32'h1020,     1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,       32'h3,       32'h0,       1'b0, 32'h0,        1'b1, 32'h13,       1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h40,      32'h0,       1'b0, 32'h0,        1'b1, 32'h13,       1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b1, 32'h80,       1'b0, 32'h80,       1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80,       32'h2,       32'h0,       1'b0, 32'h0,        1'b1, 32'h82,       1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b0, 32'h0,        1'b0, 32'h84,       1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,       32'h0,       1'b1, 32'h500,      1'b0, 32'h88,       1'b1, 1'b0, 1'b0};

    drive_a('{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    drive_b(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 32'h0, 1'b0, 1'b0);
`ifdef PC_REDIRECT_CNT_EN
    chk("reset.cnt", ifa.redirect_cnt_o, 32'h0);
`endif

    @(negedge clk);
    rst_n_a = 1'b1;
    drive_a(tbl[0]);
    #1;
    chk_a("boot", 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_a("run0", 32'h0, 1'b1, 1'b0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_a(tbl[i]);
      #1;
      chk($sformatf("v%0d.redirect", i), 32'(ifa.redirect_o), 32'(tbl[i].e_red));
`ifdef PC_REDIRECT_CNT_EN
      cnt_before = ifa.redirect_cnt_o;
`endif
      @(posedge clk);
      #1;
      chk_a($sformatf("v%0d", i), tbl[i].e_pc, tbl[i].e_val, tbl[i].e_mis);
`ifdef PC_REDIRECT_CNT_EN
      chk($sformatf("v%0d.cnt", i), ifa.redirect_cnt_o, cnt_before + 32'(tbl[i].e_inc));
`endif
    end

    // enter TRAP, then reset while trap_clear and a redirect are both high
    @(negedge clk);
    drive_a('{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    chk_a("trap_in", 32'h1, 1'b0, 1'b1);
    @(negedge clk);
    rst_n_a = 1'b0;
    drive_a('{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    chk_a("rst_trap", 32'h0, 1'b0, 1'b0);
`ifdef PC_REDIRECT_CNT_EN
    chk("rst_trap.cnt", ifa.redirect_cnt_o, 32'h0);
`endif

    // C_EXT=0 instance with a non-zero reset vector
    @(negedge clk);
    rst_n_b = 1'b1;
    drive_b(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk_b("b.boot", 32'h1000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_b("b.run0", 32'h1000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk_b("b.seq16as32", 32'h1004, 1'b1, 1'b0);
    @(negedge clk);
    drive_b(1'b1, 32'h40, 32'h6, 1'b0, 32'h0);
    #1;
    chk("b.redirect", 32'(ifb.redirect_o), 32'h1);
    @(posedge clk);
    #1;
    chk_b("b.trap", 32'h46, 1'b0, 1'b1);
    @(negedge clk);
    drive_b(1'b0, 32'h0, 32'h0, 1'b1, 32'h80);
    @(posedge clk);
    #1;
    chk_b("b.clear", 32'h80, 1'b1, 1'b0);
    @(negedge clk);
    drive_b(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    chk_b("b.seq", 32'h84, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
